// File: rtl/ext_irq_ctrl.sv
// rtl/ext_irq_ctrl.sv - fixed-priority external interrupt controller with Wishbone register window
// Optional meip_o ack-timeout re-arbitration is built when IRQ_ACK_TIMEOUT_EN is defined.
module ext_irq_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               irq_ack_i,
  output logic               meip_o,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_SRC-1:0] pending_q, pending_n;
  logic [NUM_SRC-1:0] enable_q, edge_q;
  logic [NUM_SRC-1:0] pe, rise, clr, svc_cur, svc_next;
  logic [4:0]         claim_id_q, win_idx;
  logic               wb_req, wr_en, ack_take, complete_take;
  logic [2:0]         reg_sel;
  logic [31:0]        rd_data;
  logic               unused_ok;

`ifdef IRQ_ACK_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        status_q;
  logic        timeout_fire;
`endif

  assign unused_ok = ^{wb_adr_i[1:0], (ACK_TIMEOUT > 0)};

  assign wb_req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en   = wb_req & wb_we_i;
  assign reg_sel = wb_adr_i[4:2];
  assign rise    = sync2_q & ~sync3_q;
  assign pe      = pending_q & enable_q;

  assign ack_take      = (state_q == ASSERT) && (|pe) && irq_ack_i;
  assign complete_take = wr_en && (reg_sel == 3'd4) && (state_q == SERVICE) &&
                         (wb_dat_i == {27'd0, claim_id_q});

`ifdef IRQ_ACK_TIMEOUT_EN
  assign timeout_fire = (state_q == ASSERT) && (|pe) && !irq_ack_i && meip_o &&
                        (cnt_q == 32'(ACK_TIMEOUT - 1));
`endif

  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pe[i]) win_idx = 5'(i);
    end
  end

  // svc_next is the in-service mask after this edge, so a completing level
  // source re-pends immediately and a freshly claimed one drops at once.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      svc_cur[i]  = (state_q == SERVICE) && (claim_id_q == 5'(i + 1));
      clr[i]      = ack_take && (win_idx == 5'(i));
      svc_next[i] = ack_take ? clr[i] : (complete_take ? 1'b0 : svc_cur[i]);
      if (edge_q[i])
        pending_n[i] = (pending_q[i] & ~clr[i]) | (rise[i] & ~svc_cur[i]);
      else
        pending_n[i] = sync2_q[i] & ~svc_next[i];
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      3'd0: rd_data[NUM_SRC-1:0] = pending_q;
      3'd1: rd_data[NUM_SRC-1:0] = enable_q;
      3'd2: rd_data[NUM_SRC-1:0] = edge_q;
      3'd3: rd_data[4:0]         = claim_id_q;
`ifdef IRQ_ACK_TIMEOUT_EN
      3'd5: rd_data[0]           = status_q;
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      pending_q <= '0;
    end else begin
      sync1_q   <= irq_src_i;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      pending_q <= pending_n;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      enable_q <= '0;
      edge_q   <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
`ifdef IRQ_ACK_TIMEOUT_EN
      status_q <= 1'b0;
`endif
    end else begin
      wb_ack_o <= wb_req;
      wb_dat_o <= wb_req ? rd_data : '0;
      if (wr_en && reg_sel == 3'd1) enable_q <= wb_dat_i[NUM_SRC-1:0];
      if (wr_en && reg_sel == 3'd2) edge_q   <= wb_dat_i[NUM_SRC-1:0];
`ifdef IRQ_ACK_TIMEOUT_EN
      if (timeout_fire)
        status_q <= 1'b1;
      else if (wr_en && reg_sel == 3'd5 && wb_dat_i[0])
        status_q <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      meip_o     <= 1'b0;
      claim_id_q <= '0;
`ifdef IRQ_ACK_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|pe) begin
            state_q <= ASSERT;
            meip_o  <= 1'b1;
          end
`ifdef IRQ_ACK_TIMEOUT_EN
          cnt_q <= '0;
`endif
        end
        ASSERT: begin
          if (!(|pe)) begin
            state_q <= IDLE;
            meip_o  <= 1'b0;
`ifdef IRQ_ACK_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end else if (irq_ack_i) begin
            claim_id_q <= win_idx + 5'd1;
            meip_o     <= 1'b0;
            state_q    <= SERVICE;
`ifdef IRQ_ACK_TIMEOUT_EN
            cnt_q      <= '0;
          end else if (!meip_o) begin
            meip_o <= 1'b1;
            cnt_q  <= '0;
          end else if (timeout_fire) begin
            meip_o <= 1'b0;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
`endif
          end
        end
        SERVICE: begin
          if (complete_take) begin
            claim_id_q <= '0;
            state_q    <= IDLE;
          end
`ifdef IRQ_ACK_TIMEOUT_EN
          cnt_q <= '0;
`endif
        end
        default: begin
          state_q <= IDLE;
          meip_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// tb/tb_ext_irq_ctrl.sv - scoreboard bench for ext_irq_ctrl with randomized source patterns
module tb_ext_irq_ctrl;

  localparam logic [4:0] A_PEND = 5'h00, A_EN = 5'h04, A_EDGE = 5'h08;
  localparam logic [4:0] A_CLAIM = 5'h0C, A_COMP = 5'h10, A_STAT = 5'h14, A_BAD = 5'h18;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  irq_src = '0;
  logic        irq_ack = 1'b0;
  logic        meip;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [4:0]  wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [31:0] wb_rdat;
  logic        wb_ack;

  int checks = 0;
  int errors = 0;

  bit          rd_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  ext_irq_ctrl #(.NUM_SRC(8), .ACK_TIMEOUT(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .irq_src_i(irq_src), .irq_ack_i(irq_ack),
    .meip_o(meip), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(wb_rdat), .wb_ack_o(wb_ack)
  );

  // Monitor: pops one scoreboard entry per bus ack and compares read data.
  initial begin
    forever begin
      @(negedge clk);
      if (wb_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: ack seen with no outstanding transfer");
        end else begin
          bit          rd;
          logic [31:0] e;
          string       nm;
          rd = rd_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
          if (rd) begin
            checks++;
            if (wb_rdat !== e) begin
              errors++;
              $display("FAIL %s: read %h expected %h", nm, wb_rdat, e);
            end
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input bit we, input logic [4:0] adr, input logic [31:0] dat,
                         input logic [31:0] exp, input string nm);
    int n;
    @(negedge clk);
    rd_q.push_back(!we); exp_q.push_back(exp); name_q.push_back(nm);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!wb_ack && n < 10);
    if (!wb_ack) begin
      checks++; errors++;
      $display("FAIL wb_timeout %s: no ack within 10 cycles", nm);
      void'(rd_q.pop_back()); void'(exp_q.pop_back()); void'(name_q.pop_back());
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [4:0] adr, input logic [31:0] exp, input string nm);
    wb_xfer(1'b0, adr, 32'd0, exp, nm);
  endtask

  task automatic wb_write(input logic [4:0] adr, input logic [31:0] dat);
    wb_xfer(1'b1, adr, dat, 32'd0, "write");
  endtask

  task automatic pulse_ack;
    @(negedge clk);
    irq_ack = 1'b1;
    @(posedge clk); #1;
    irq_ack = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset_i = 1'b1; irq_src = '0;
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  // Reference: lowest set bit index, or -1 when none.
  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    logic [7:0] en, ed, r, keep, pend, pend2, pe;
    int w;

    tick(2);
    reset_i = 1'b0;
    check("reset_meip", {31'd0, meip}, 32'd0);
    wb_read(A_PEND, 32'd0, "reset_pending");
    wb_read(A_CLAIM, 32'd0, "reset_claim");
    wb_read(A_STAT, 32'd0, "reset_status");

    // Level source 0: latency, claim, complete with source still high.
    wb_write(A_EN, 32'h01);
    @(negedge clk);
    irq_src[0] = 1'b1;
    tick(3);
    check("latency_edge3_meip", {31'd0, meip}, 32'd0);
    tick(1);
    check("latency_edge4_meip", {31'd0, meip}, 32'd1);
    pulse_ack;
    check("ack_drops_meip", {31'd0, meip}, 32'd0);
    wb_read(A_CLAIM, 32'd1, "claim_src0");
    wb_write(A_COMP, 32'd1);
    check("complete_meip_low", {31'd0, meip}, 32'd0);
    tick(1);
    check("complete_rearm_meip", {31'd0, meip}, 32'd1);

    // Asynchronous reset while in ASSERT.
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    check("async_reset_meip", {31'd0, meip}, 32'd0);
    @(negedge clk);
    reset_i = 1'b0; irq_src = '0;
    wb_read(A_PEND, 32'd0, "rst_pending");
    wb_read(A_EN, 32'd0, "rst_enable");
    wb_read(A_EDGE, 32'd0, "rst_edge");
    wb_read(A_CLAIM, 32'd0, "rst_claim");

    // Simultaneous rising edges on sources 5 and 2.
    wb_write(A_EN, 32'hFF);
    wb_write(A_EDGE, 32'hFF);
    @(negedge clk);
    irq_src = 8'h24;
    tick(6);
    check("edge_meip", {31'd0, meip}, 32'd1);
    pulse_ack;
    wb_read(A_CLAIM, 32'd3, "edge_claim3");
    wb_read(A_PEND, 32'h20, "edge_pending_after_claim");
    wb_write(A_COMP, 32'd4);
    wb_read(A_CLAIM, 32'd3, "wrong_complete_claim");
    check("wrong_complete_meip", {31'd0, meip}, 32'd0);
    wb_write(A_COMP, 32'd3);
    tick(1);
    check("second_irq_meip", {31'd0, meip}, 32'd1);
    pulse_ack;
    wb_read(A_CLAIM, 32'd6, "edge_claim6");
    wb_read(A_COMP, 32'd0, "complete_reads0");
    wb_write(A_BAD, 32'hFFFF_FFFF);
    wb_read(A_BAD, 32'd0, "unmapped_reads0");

    // ENABLE cleared while asserting.
    do_reset;
    wb_write(A_EN, 32'h02);
    @(negedge clk);
    irq_src[1] = 1'b1;
    tick(6);
    check("en_drop_meip_before", {31'd0, meip}, 32'd1);
    wb_write(A_EN, 32'h00);
    tick(1);
    check("en_drop_meip_after", {31'd0, meip}, 32'd0);
    wb_read(A_PEND, 32'h02, "en_drop_pending");
    pulse_ack;
    wb_read(A_CLAIM, 32'd0, "ack_in_idle_ignored");

`ifdef IRQ_ACK_TIMEOUT_EN
    do_reset;
    wb_write(A_EN, 32'h01);
    @(negedge clk);
    irq_src[0] = 1'b1;
    w = 0;
    while (!meip && w < 10) begin tick(1); w++; end
    check("to_meip_rise", {31'd0, meip}, 32'd1);
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      check("to_meip_hold", {31'd0, meip}, 32'd1);
    end
    tick(1);
    check("to_meip_drop", {31'd0, meip}, 32'd0);
    tick(1);
    check("to_meip_restore", {31'd0, meip}, 32'd1);
    wb_read(A_STAT, 32'd1, "to_status_set");
    wb_write(A_STAT, 32'd1);
    wb_read(A_STAT, 32'd0, "to_status_cleared");
`else
    wb_write(A_STAT, 32'd1);
    wb_read(A_STAT, 32'd0, "status_disabled");
`endif

    // Randomized patterns against the rule-level model.
    for (int it = 0; it < 16; it++) begin
      do_reset;
      en = 8'($urandom); ed = 8'($urandom); r = 8'($urandom); keep = 8'($urandom);
      wb_write(A_EN, {24'd0, en});
      wb_write(A_EDGE, {24'd0, ed});
      wb_read(A_EN, {24'd0, en}, "rnd_enable");
      wb_read(A_EDGE, {24'd0, ed}, "rnd_edge");
      @(negedge clk); irq_src = r;
      tick(6);
      @(negedge clk); irq_src = r & keep;
      tick(6);
      pend = (ed & r) | (~ed & r & keep);
      pe = pend & en;
      wb_read(A_PEND, {24'd0, pend}, "rnd_pending");
      check("rnd_meip", {31'd0, meip}, {31'd0, (pe != 0)});
      w = lowest(pe);
      pulse_ack;
      if (w < 0) begin
        wb_read(A_CLAIM, 32'd0, "rnd_claim_none");
      end else begin
        wb_read(A_CLAIM, 32'(w + 1), "rnd_claim");
        wb_read(A_PEND, {24'd0, pend & ~(8'd1 << w)}, "rnd_pending_claimed");
        wb_write(A_COMP, 32'(w + 1));
        pend2 = (pend & ~(8'd1 << w)) | ((~ed & r & keep) & (8'd1 << w));
        tick(3);
        wb_read(A_CLAIM, 32'd0, "rnd_claim_after_complete");
        wb_read(A_PEND, {24'd0, pend2}, "rnd_pending_after_complete");
        check("rnd_meip_after_complete", {31'd0, meip}, {31'd0, ((pend2 & en) != 0)});
      end
    end

    tick(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
